// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the machine-level interrupt controller: register map
// and compare-register reset value.
package intr_ctrl_pkg;

   localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
   localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
   localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] ADDR_PRESCALE    = 3'd4;
   localparam logic [2:0] ADDR_PENDING     = 3'd5;
   localparam logic [2:0] ADDR_ENABLE      = 3'd6;
   localparam logic [2:0] ADDR_CLAIM       = 3'd7;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/intr_gateway.sv
// One external interrupt source: two-flop synchroniser, rising-edge detect
// and a sticky pending flop cleared by claim (a new edge wins over the claim).
module intr_gateway (
   input  logic clk,
   input  logic rstn,
   input  logic src,
   input  logic claim_clr,
   output logic pending
);

   logic sync1_r;
   logic sync2_r;
   logic sync3_r;
   logic pending_r;

   // Synchroniser chain, edge history and pending state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         sync3_r   <= 1'b0;
         pending_r <= 1'b0;
      end else begin
         sync1_r   <= src;
         sync2_r   <= sync1_r;
         sync3_r   <= sync2_r;
         pending_r <= (pending_r & ~claim_clr) | (sync2_r & ~sync3_r);
      end
   end

   assign pending = pending_r;

endmodule

// File: rtl/intr_ctrl.sv
// Machine timer (mtime/mtimecmp with prescaler) and external interrupt
// gateway behind a word-addressed register port with one-cycle response.
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int N_SRC      = 4,
   parameter int PRESCALE_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N_SRC-1:0]  ext_src,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              timer_intr,
   output logic              ext_intr
);

   logic [63:0]           mtime_r;
   logic [63:0]           mtime_nxt_s;
   logic [63:0]           mtimecmp_r;
   logic [63:0]           mtimecmp_nxt_s;
   logic [PRESCALE_W-1:0] prescale_r;
   logic [PRESCALE_W-1:0] pcnt_r;
   logic [PRESCALE_W-1:0] pcnt_nxt_s;
   logic [31:0]           hi_shadow_r;
   logic [N_SRC-1:0]      enable_r;
   logic [N_SRC-1:0]      pending_s;
   logic [N_SRC-1:0]      active_s;
   logic [N_SRC-1:0]      claim_sel_s;
   logic [N_SRC-1:0]      claim_clr_s;
   logic [31:0]           claim_id_s;
   logic [31:0]           rdata_s;
   logic                  found_s;
   logic                  wr_s;
   logic                  rd_s;
   logic                  tick_s;

   assign wr_s     = req_valid & req_we;
   assign rd_s     = req_valid & ~req_we;
   assign active_s = pending_s & enable_r;
   assign tick_s   = (pcnt_r == prescale_r);

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      intr_gateway u_gw (
         .clk       (clk),
         .rstn      (rstn),
         .src       (ext_src[g]),
         .claim_clr (claim_clr_s[g]),
         .pending   (pending_s[g])
      );
   end

   // Lowest-numbered enabled pending source wins the claim
   always_comb begin
      found_s     = 1'b0;
      claim_id_s  = 32'd0;
      claim_sel_s = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (active_s[i] && !found_s) begin
            found_s        = 1'b1;
            claim_id_s     = 32'(i + 1);
            claim_sel_s[i] = 1'b1;
         end else begin
            claim_sel_s[i] = 1'b0;
         end
      end
      if (rd_s && (req_addr == ADDR_CLAIM)) begin
         claim_clr_s = claim_sel_s;
      end else begin
         claim_clr_s = '0;
      end
   end

   always_comb begin
      rdata_s = 32'd0;
      case (req_addr)
         ADDR_MTIME_LO:    rdata_s = mtime_r[31:0];
         ADDR_MTIME_HI:    rdata_s = hi_shadow_r;
         ADDR_MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
         ADDR_MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
         ADDR_PRESCALE:    rdata_s = 32'(prescale_r);
         ADDR_PENDING:     rdata_s = 32'(pending_s);
         ADDR_ENABLE:      rdata_s = 32'(enable_r);
         ADDR_CLAIM:       rdata_s = claim_id_s;
         default:          rdata_s = 32'd0;
      endcase
   end

   // Software writes to a timer half override the increment, with no carry
   always_comb begin
      pcnt_nxt_s     = pcnt_r;
      mtime_nxt_s    = mtime_r;
      mtimecmp_nxt_s = mtimecmp_r;
      if (wr_s && (req_addr == ADDR_PRESCALE)) begin
         pcnt_nxt_s = '0;
      end else if (tick_s) begin
         pcnt_nxt_s = '0;
      end else begin
         pcnt_nxt_s = pcnt_r + PRESCALE_W'(1);
      end
      if (wr_s && (req_addr == ADDR_MTIME_LO)) begin
         mtime_nxt_s = {mtime_r[63:32], req_wdata};
      end else if (wr_s && (req_addr == ADDR_MTIME_HI)) begin
         mtime_nxt_s = {req_wdata, mtime_r[31:0]};
      end else if (tick_s) begin
         mtime_nxt_s = mtime_r + 64'd1;
      end else begin
         mtime_nxt_s = mtime_r;
      end
      if (wr_s && (req_addr == ADDR_MTIMECMP_LO)) begin
         mtimecmp_nxt_s = {mtimecmp_r[63:32], req_wdata};
      end else if (wr_s && (req_addr == ADDR_MTIMECMP_HI)) begin
         mtimecmp_nxt_s = {req_wdata, mtimecmp_r[31:0]};
      end else begin
         mtimecmp_nxt_s = mtimecmp_r;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mtime_r     <= 64'd0;
         mtimecmp_r  <= MTIMECMP_RESET;
         pcnt_r      <= '0;
         prescale_r  <= '0;
         hi_shadow_r <= 32'd0;
         enable_r    <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'd0;
         timer_intr  <= 1'b0;
         ext_intr    <= 1'b0;
      end else begin
         mtime_r    <= mtime_nxt_s;
         mtimecmp_r <= mtimecmp_nxt_s;
         pcnt_r     <= pcnt_nxt_s;
         timer_intr <= (mtime_nxt_s >= mtimecmp_nxt_s);
         ext_intr   <= |active_s;
         rsp_valid  <= req_valid;
         rsp_rdata  <= rd_s ? rdata_s : 32'd0;
         if (wr_s && (req_addr == ADDR_PRESCALE)) begin
            prescale_r <= req_wdata[PRESCALE_W-1:0];
         end
         if (wr_s && (req_addr == ADDR_ENABLE)) begin
            enable_r <= req_wdata[N_SRC-1:0];
         end
         if (rd_s && (req_addr == ADDR_MTIME_LO)) begin
            hi_shadow_r <= mtime_r[63:32];
         end
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expected responses are queued at issue time
// and popped by a monitor whenever rsp_valid is seen.
module tb_intr_ctrl;
   import intr_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  ext_src;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        timer_intr;
   logic        ext_intr;

   int compared   = 0;
   int mismatched = 0;
   logic [34:0] exp_q[$];

   intr_ctrl #(.N_SRC(4), .PRESCALE_W(16)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ext_src    (ext_src),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .timer_intr (timer_intr),
      .ext_intr   (ext_intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Drive one request for a cycle; caller is positioned #1 after a posedge
   task automatic req(input logic we, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      exp_q.push_back({a, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      req(1'b1, a, d, 32'd0);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      req(1'b0, a, 32'd0, exp);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Must be called in the same cycle rstn is released, so mtime still reads 0
   task automatic readout_reset();
      chk("timer_intr_reset", {31'd0, timer_intr}, 32'd0);
      chk("ext_intr_reset", {31'd0, ext_intr}, 32'd0);
      rd(ADDR_MTIME_LO,    32'h0000_0000);
      rd(ADDR_MTIME_HI,    32'h0000_0000);
      rd(ADDR_MTIMECMP_LO, 32'hFFFF_FFFF);
      rd(ADDR_MTIMECMP_HI, 32'hFFFF_FFFF);
      rd(ADDR_PRESCALE,    32'h0000_0000);
      rd(ADDR_PENDING,     32'h0000_0000);
      rd(ADDR_ENABLE,      32'h0000_0000);
      rd(ADDR_CLAIM,       32'h0000_0000);
      idle(1);
   endtask

   always @(negedge clk) begin
      logic [34:0] e;
      if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 data 0x%08h, required no response",
                     rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("rsp_addr%0d", e[34:32]), rsp_rdata, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      rstn      = 1'b0;
      ext_src   = 4'b0000;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 3'd0;
      req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      readout_reset();

      // Prescaled timer: mtime = 1 from cycle 5, stepping every 4 cycles
      wr(ADDR_PRESCALE,    32'd3);
      wr(ADDR_MTIME_HI,    32'd0);
      wr(ADDR_MTIME_LO,    32'd0);
      wr(ADDR_MTIMECMP_HI, 32'd0);
      wr(ADDR_MTIMECMP_LO, 32'd5);
      for (int c = 5; c <= 20; c++) begin
         chk("timer_below_cmp", {31'd0, timer_intr}, 32'd0);
         rd(ADDR_MTIME_LO, 32'((c - 1) / 4));
      end
      chk("timer_at_cmp", {31'd0, timer_intr}, 32'd1);
      rd(ADDR_MTIME_LO, 32'd5);
      chk("timer_held", {31'd0, timer_intr}, 32'd1);
      wr(ADDR_MTIMECMP_LO, 32'd100);
      chk("timer_after_cmp_raise", {31'd0, timer_intr}, 32'd0);
      idle(1);

      // Carry into the high word and hi_shadow snapshot
      wr(ADDR_PRESCALE, 32'd0);
      wr(ADDR_MTIME_HI, 32'd0);
      wr(ADDR_MTIME_LO, 32'hFFFF_FFFE);
      idle(1);
      rd(ADDR_MTIME_LO, 32'hFFFF_FFFF);
      rd(ADDR_MTIME_HI, 32'h0000_0000);
      rd(ADDR_MTIME_LO, 32'h0000_0001);
      rd(ADDR_MTIME_HI, 32'h0000_0001);

      // External gateway latency, claim order and disabled-pending retention
      wr(ADDR_ENABLE, 32'h0000_000A);
      ext_src = 4'b1110;
      chk("ext_p0", {31'd0, ext_intr}, 32'd0);
      idle(1);
      ext_src = 4'b0000;
      chk("ext_p1", {31'd0, ext_intr}, 32'd0);
      idle(1);
      chk("ext_p2", {31'd0, ext_intr}, 32'd0);
      idle(1);
      chk("ext_p3", {31'd0, ext_intr}, 32'd0);
      idle(1);
      chk("ext_p4", {31'd0, ext_intr}, 32'd1);
      rd(ADDR_CLAIM, 32'd2);
      rd(ADDR_CLAIM, 32'd4);
      chk("ext_before_drop", {31'd0, ext_intr}, 32'd1);
      rd(ADDR_CLAIM, 32'd0);
      chk("ext_after_drop", {31'd0, ext_intr}, 32'd0);
      rd(ADDR_PENDING, 32'h0000_0004);

      // Claim of source 1 coinciding with a fresh edge on source 1
      ext_src = 4'b0010;
      idle(1);
      ext_src = 4'b0000;
      idle(3);
      ext_src = 4'b0010;
      idle(1);
      ext_src = 4'b0000;
      idle(1);
      rd(ADDR_CLAIM, 32'd2);
      rd(ADDR_CLAIM, 32'd2);
      rd(ADDR_CLAIM, 32'd0);
      rd(ADDR_PENDING, 32'h0000_0004);

      // Reset lands on an in-flight read: no response may follow
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = ADDR_MTIME_LO;
      rstn      = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      readout_reset();

      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Machine-level interrupt source for the core: a 64-bit `mtime`/`mtimecmp` timer that drives `timer_intr` and an edge-triggered external-interrupt gateway with pending, enable and claim state that drives `ext_intr`. It is the producer side of the core's `timer_intr`/`ext_intr` inputs. Software programs it through a word-addressed register port with a fixed one-cycle response.

## Interface
- `N_SRC`, 4: number of external interrupt sources (1..31).
- `PRESCALE_W`, 16: width of the prescaler register.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low. Clock is `clk`.
- `ext_src`  in  N_SRC  asynchronous external interrupt lines; a rising edge requests an interrupt.
- `req_valid`  in  1  register access request; always accepted.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  3  word address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response strobe, exactly one cycle after each request.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `timer_intr`  out  1  level timer interrupt to the core.
- `ext_intr`  out  1  level external interrupt to the core.

## Operation
- Register map (read/write unless noted):
  - 0 `MTIME_LO`. A read also snapshots `mtime[63:32]` into `hi_shadow`.
  - 1 `MTIME_HI`. A read returns `hi_shadow`; a write sets `mtime[63:32]`.
  - 2 `MTIMECMP_LO`.
  - 3 `MTIMECMP_HI`.
  - 4 `PRESCALE`, lower PRESCALE_W bits; upper bits read 0.
  - 5 `PENDING`, read-only; writes are ignored.
  - 6 `ENABLE`, N_SRC bits.
  - 7 `CLAIM`: see below; writes are ignored.
- Prescaler:
  - `pcnt` counts 0..PRESCALE.
  - When `pcnt == PRESCALE`, `pcnt` returns to 0 and `mtime` increments by 1, wrapping at 2^64.
  - PRESCALE = 0 means `mtime` increments every cycle.
  - Writing PRESCALE clears `pcnt`.
- A write to `MTIME_LO` or `MTIME_HI` takes precedence over an increment in the same cycle. The other half is unchanged, with no carry.
- `timer_intr` is registered `mtime >= mtimecmp`, an unsigned 64-bit compare evaluated on the post-update values.
- External gateway, per source:
  - Two-flop synchroniser, then rising-edge detect.
  - An edge sets `pending[i]`; the pending bit stays set until claimed.
  - `ext_intr` is registered `|(pending & enable)`.
- CLAIM read:
  - Returns `i+1` for the lowest `i` with `pending[i] & enable[i]`, or 0 if there is none.
  - Clears that `pending[i]` in the same cycle.
  - Disabled pending bits are retained and not claimable.
- Simultaneous claim and new edge on the same source: the set wins, so the bit stays pending.
- Reset values:
  - `mtime` = 0, `pcnt` = 0, `PRESCALE` = 0.
  - `mtimecmp` = all ones.
  - `pending`, `enable`, `hi_shadow`, synchroniser flops = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `timer_intr` = 0, `ext_intr` = 0.

## Timing
- Request sampled at edge T → `rsp_valid` = 1 with data during T+1. Back-to-back requests give back-to-back responses.
- Read data reflects register state before any update made at edge T.
- Register writes take effect at edge T.
- Interrupt outputs:
  - `timer_intr` rises one cycle after `mtime` reaches `mtimecmp`.
  - `timer_intr` falls one cycle after a `MTIMECMP` write raises the compare value above `mtime`.
  - `ext_src` edge → `pending` set 3 cycles later: 2 synchroniser stages plus the edge register.
  - `pending` set → `ext_intr` asserts 1 cycle after that.
  - `ext_intr` deasserts the cycle after the claim clears the last enabled pending bit.
- `rstn` low at any edge restores every reset value, including a request in flight: no `rsp_valid` follows.

## Structure
- `intr_ctrl_pkg` holds:
  - the register address localparams (`ADDR_MTIME_LO` .. `ADDR_CLAIM`);
  - the `MTIMECMP_RESET` constant.
- One sub-module, `intr_gateway`:
  - Per-source synchroniser, edge detect and pending flop.
  - Ports: `clk`, `rstn`, `src`, `claim_clr`, `pending`.
  - Instantiated N_SRC times via generate.
- Priority encoder for CLAIM and the 64-bit compare live in `intr_ctrl`.

## Test plan
- Reset, then read all 8 addresses → `MTIMECMP_LO`/`MTIMECMP_HI` = 0xFFFFFFFF, all other reads 0; `timer_intr` = 0, `ext_intr` = 0.
- PRESCALE = 3, `MTIMECMP` = 5 → `mtime` steps every 4 cycles; `timer_intr` asserts 1 cycle after `mtime` reaches 5; write `MTIMECMP_LO` = 100 → `timer_intr` deasserts the next cycle.
- Write `MTIME_HI` = 0, `MTIME_LO` = 0xFFFFFFFE with PRESCALE = 0 → `mtime` carries into the high word at the wrap. Read LO, then HI → HI returns the value snapshotted at the LO read.
- ENABLE = 0b1010, pulse `ext_src` = 0b1110:
  - `ext_intr` rises 4 cycles after the pulse.
  - CLAIM reads 2, then 4, then 0; `ext_intr` drops after the second claim.
  - `PENDING` still reads 0b0100.
- Claim of source 1 issued in the same cycle its new edge lands in `pending` → `pending[1]` stays 1 and the next CLAIM returns 2.
- `rstn` pulsed low the cycle after a read request → no `rsp_valid`; all registers return to their reset values.
